// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry ripples through STAGES registered
// CW-bit chunks, with NZCV flags and valid/ready handshakes at both ends.
module pipelined_add_sub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic [3:0]       flags_out
);

    localparam int CW = WIDTH / STAGES;

    // Operands are shifted right one chunk per stage so the live chunk always sits
    // at bits [CW-1:0]; partial sums are shifted in from the top, so after the last
    // stage the result is fully aligned.
    logic             vld_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];

    logic             vld_nx [STAGES];
    logic [WIDTH-1:0] a_nx   [STAGES];
    logic [WIDTH-1:0] b_nx   [STAGES];
    logic [WIDTH-1:0] s_nx   [STAGES];
    logic             c_nx   [STAGES];
    logic [3:0]       flags_nx;
    logic             adv;

    function automatic logic [CW:0] add_chunk(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b,
                                              input logic          cin);
        return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    endfunction

    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] s,
                                        input logic             c,
                                        input logic             a_msb,
                                        input logic             b_msb);
        return {s[WIDTH-1], (s == '0), c, (a_msb == b_msb) && (s[WIDTH-1] != a_msb)};
    endfunction

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p[STAGES-1];
    assign sum_out   = s_p[STAGES-1];

    always_comb begin
        logic [WIDTH-1:0] b0;
        logic [CW:0]      t;
        logic             a_msb;
        logic             b_msb;

        // Stage 0 boundary: operand conditioning and lowest chunk
        b0        = sub_in ? ~b_in : b_in;
        t         = add_chunk(a_in[CW-1:0], b0[CW-1:0], sub_in);
        vld_nx[0] = in_valid;
        a_nx[0]   = a_in >> CW;
        b_nx[0]   = b0 >> CW;
        s_nx[0]   = '0;
        s_nx[0][WIDTH-1 -: CW] = t[CW-1:0];
        c_nx[0]   = t[CW];
        a_msb     = a_in[CW-1];
        b_msb     = b0[CW-1];

        // Stage k boundary: next chunk with carry from the previous stage
        for (int k = 1; k < STAGES; k++) begin
            t         = add_chunk(a_p[k-1][CW-1:0], b_p[k-1][CW-1:0], c_p[k-1]);
            vld_nx[k] = vld_p[k-1];
            a_nx[k]   = a_p[k-1] >> CW;
            b_nx[k]   = b_p[k-1] >> CW;
            s_nx[k]   = s_p[k-1] >> CW;
            s_nx[k][WIDTH-1 -: CW] = t[CW-1:0];
            c_nx[k]   = t[CW];
            a_msb     = a_p[k-1][CW-1];
            b_msb     = b_p[k-1][CW-1];
        end

        flags_nx = nzcv(s_nx[STAGES-1], c_nx[STAGES-1], a_msb, b_msb);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
            end
            flags_out <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= vld_nx[k];
                a_p[k]   <= a_nx[k];
                b_p[k]   <= b_nx[k];
                s_p[k]   <= s_nx[k];
                c_p[k]   <= c_nx[k];
            end
            flags_out <= flags_nx;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: scoreboard queue filled on accept,
// drained and compared by a negedge monitor.
module tb_pipelined_add_sub;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic [3:0]       flags_out;

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .flags_out (flags_out)
    );

    typedef struct {
        logic [63:0] s;
        logic [3:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [63:0] bp;
        logic [64:0] full;
        logic [63:0] r;
        bp   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {64'd0, s};
        r    = full[63:0];
        return {r, r[63], (r == 64'd0), full[64], (a[63] == bp[63]) && (r[63] != a[63])};
    endfunction

    // Scoreboard monitor: retire on out_valid & out_ready
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'd0, 64'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", sum_out, e.s);
                check("flags", {60'd0, flags_out}, {60'd0, e.f});
                if (e.lat) check("latency", 64'(cyc - e.acc), 64'(STAGES - 1));
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] es, input logic [3:0] ef);
        bit done;
        done     = 1'b0;
        a_in     = a;
        b_in     = b;
        sub_in   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{es, ef, cyc + 1, lat_chk});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("accept_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic send_m(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [67:0] r;
        r = model(a, b, s);
        send(a, b, s, r[67:4], r[3:0]);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] held;
        bit          seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        sub_in    = 1'b0;
        held      = '0;
        seen      = 1'b0;

        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", sum_out, 64'd0);
        check("rst_flags", {60'd0, flags_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed arithmetic vectors, back-to-back
        send(64'd5,   64'd10,   1'b0, 64'd15,   4'b0000);
        send(64'd280, 64'd1000, 1'b0, 64'd1280, 4'b0000);
        send(64'd280, 64'd1000, 1'b1, 64'hFFFF_FFFF_FFFF_FD30, 4'b1000);
        send(-64'd54321, 64'd1000, 1'b0, 64'hFFFF_FFFF_FFFF_2FB7, 4'b1000);
        send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 4'b0000);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
        send(64'd1000, 64'd1000, 1'b1, 64'd0, 4'b0110);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        in_valid = 1'b0;
        drain();

        // Backpressure: 6 back-to-back operations, 3-cycle stall after first result
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_m(64'(i + 1) * 64'h0123_4567_89AB_CDEF,
                           {32'(i * 77), 32'hFFFF_0000 ^ 32'(i)}, i[0]);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("bp_first_valid", {63'd0, seen}, 64'd1);
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                held = sum_out;
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                repeat (2) begin
                    @(negedge clk);
                    check("stall_sum_stable", sum_out, held);
                    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with three operations in flight
        send(64'd1, 64'd2, 1'b0, 64'd3, 4'b0000);
        send(64'd3, 64'd4, 1'b0, 64'd7, 4'b0000);
        send(64'd5, 64'd6, 1'b0, 64'd11, 4'b0000);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        q.delete();
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_sum", sum_out, 64'd0);
        check("midrst_flags", {60'd0, flags_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (6) begin
            @(negedge clk);
            check("no_stale_valid", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;
        send(64'd5, 64'd10, 1'b0, 64'd15, 4'b0000);
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
